// File: rtl/pong_match_if.sv
// Event and status bundle between the Pong match sequencer and the ball/paddle engine.
// master drives the frame/button/goal events, slave is the match controller.
interface pong_match_if;
   logic       frame_tick;
   logic       start_btn;
   logic       goal_left;
   logic       goal_right;
   logic       ball_enable;
   logic       ball_reset;
   logic       serve_dir;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [1:0] winner;
   logic [2:0] state;

   modport master (
      output frame_tick, start_btn, goal_left, goal_right,
      input  ball_enable, ball_reset, serve_dir, p1_score, p2_score, winner, state
   );

   modport slave (
      input  frame_tick, start_btn, goal_left, goal_right,
      output ball_enable, ball_reset, serve_dir, p1_score, p2_score, winner, state
   );
endinterface

// File: rtl/pong_match_controller.sv
// Pong match sequencer: owns scores, gates ball motion and paces serve/point-hold in video frames.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a start-button rising edge
// SERVE     | ball centred, counting SERVE_DELAY_FRAMES frame ticks
// RALLY     | ball live, waiting for a goal
// POINT     | ball frozen, counting POINT_HOLD_FRAMES frame ticks
// GAME_OVER | scores and winner held until the next start edge
module pong_match_controller #(
   parameter int WIN_SCORE          = 5,
   parameter int SERVE_DELAY_FRAMES = 60,
   parameter int POINT_HOLD_FRAMES  = 90,
   parameter int CNT_W              = 10
) (
   input  logic         clk,
   input  logic         reset,
   pong_match_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_RALLY     = 3'd2,
      ST_POINT     = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(POINT_HOLD_FRAMES - 1);
   localparam logic [3:0]       WIN_PTS    = 4'(WIN_SCORE);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       p1_q, p1_d;
   logic [3:0]       p2_q, p2_d;
   logic [1:0]       win_q, win_d;
   logic             dir_q, dir_d;
   logic             en_q, en_d;
   logic             br_q, br_d;
   logic             start_q;
   logic             start_rise;

   assign start_rise = bus.start_btn & ~start_q;

   // start_q resets high so a button held through reset cannot start a match
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         win_q   <= '0;
         dir_q   <= 1'b1;
         en_q    <= 1'b0;
         br_q    <= 1'b0;
         start_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         win_q   <= win_d;
         dir_q   <= dir_d;
         en_q    <= en_d;
         br_q    <= br_d;
         start_q <= bus.start_btn;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      win_d   = win_q;
      dir_d   = dir_q;
      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (start_rise) begin
               p1_d    = '0;
               p2_d    = '0;
               win_d   = 2'd0;
               dir_d   = 1'b1;
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (bus.frame_tick) begin
               if (cnt_q == SERVE_LAST) state_d = ST_RALLY;
               else                     cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_RALLY: begin
            // simultaneous goals are a replay: no score, serve direction kept
            if (bus.goal_left && bus.goal_right) begin
               state_d = ST_POINT;
            end else if (bus.goal_left) begin
               p2_d    = p2_q + 4'd1;
               dir_d   = 1'b0;
               state_d = ST_POINT;
            end else if (bus.goal_right) begin
               p1_d    = p1_q + 4'd1;
               dir_d   = 1'b1;
               state_d = ST_POINT;
            end
         end
         ST_POINT: begin
            if (bus.frame_tick) begin
               if (cnt_q == HOLD_LAST) begin
                  if (p1_q >= WIN_PTS) begin
                     win_d   = 2'd1;
                     state_d = ST_GAME_OVER;
                  end else if (p2_q >= WIN_PTS) begin
                     win_d   = 2'd2;
                     state_d = ST_GAME_OVER;
                  end else begin
                     state_d = ST_SERVE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   always_comb begin
      en_d = (state_d == ST_RALLY);
      br_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
   end

   assign bus.state       = state_q;
   assign bus.ball_enable = en_q;
   assign bus.ball_reset  = br_q;
   assign bus.serve_dir   = dir_q;
   assign bus.p1_score    = p1_q;
   assign bus.p2_score    = p2_q;
   assign bus.winner      = win_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: directed match walk-through, then randomized events
// against a frames-remaining reference model compared every cycle.
module tb_pong_match_controller;
   localparam int WIN = 2;
   localparam int SD  = 2;
   localparam int PH  = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   pong_match_if bus();

   pong_match_controller #(
      .WIN_SCORE(WIN), .SERVE_DELAY_FRAMES(SD), .POINT_HOLD_FRAMES(PH), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   // frame tick every 8 clocks
   initial begin
      bus.frame_tick = 1'b0;
      forever begin
         repeat (7) @(negedge clk);
         bus.frame_tick = 1'b1;
         @(negedge clk);
         bus.frame_tick = 1'b0;
      end
   end

   // reference model: expected register values after each edge
   int m_state, m_p1, m_p2, m_win, m_left;
   bit m_en, m_br, m_dir, m_prev, m_valid;
   initial m_valid = 1'b0;

   always @(posedge clk) begin
      bit rise;
      m_valid = 1'b1;
      if (reset) begin
         m_state = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_left = 0;
         m_br = 0; m_dir = 1; m_prev = 1;
      end else begin
         rise   = bus.start_btn && !m_prev;
         m_prev = bus.start_btn;
         m_br   = 0;
         if (m_state == 0 || m_state == 4) begin
            if (rise) begin
               m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1;
               m_state = 1; m_left = SD; m_br = 1;
            end
         end else if (m_state == 1) begin
            if (bus.frame_tick) begin
               m_left = m_left - 1;
               if (m_left == 0) m_state = 2;
            end
         end else if (m_state == 2) begin
            if (bus.goal_left || bus.goal_right) begin
               if (bus.goal_left && !bus.goal_right) begin m_p2++; m_dir = 0; end
               if (bus.goal_right && !bus.goal_left) begin m_p1++; m_dir = 1; end
               m_state = 3; m_left = PH;
            end
         end else if (m_state == 3) begin
            if (bus.frame_tick) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  if (m_p1 >= WIN)      begin m_win = 1; m_state = 4; end
                  else if (m_p2 >= WIN) begin m_win = 2; m_state = 4; end
                  else begin m_state = 1; m_left = SD; m_br = 1; end
               end
            end
         end
      end
      m_en = (m_state == 2);
   end

   always @(negedge clk) begin
      if (m_valid) begin
         total++;
         if (bus.state !== 3'(m_state) || bus.p1_score !== 4'(m_p1) || bus.p2_score !== 4'(m_p2) ||
             bus.winner !== 2'(m_win) || bus.ball_enable !== m_en || bus.ball_reset !== m_br ||
             bus.serve_dir !== m_dir) begin
            bad++;
            $display("FAIL model t=%0t got st=%0d p1=%0d p2=%0d w=%0d en=%0b br=%0b dir=%0b exp st=%0d p1=%0d p2=%0d w=%0d en=%0b br=%0b dir=%0b",
                     $time, bus.state, bus.p1_score, bus.p2_score, bus.winner, bus.ball_enable,
                     bus.ball_reset, bus.serve_dir, m_state, m_p1, m_p2, m_win, m_en, m_br, m_dir);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_state(input int s, input int budget);
      int n = 0;
      while (bus.state !== 3'(s) && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (bus.state !== 3'(s)) begin
         bad++;
         $display("FAIL wait_state: got %0d expected %0d within %0d clks", bus.state, s, budget);
      end
   endtask

   task automatic pulse(input bit gl, input bit gr);
      bus.goal_left  = gl;
      bus.goal_right = gr;
      @(negedge clk);
      bus.goal_left  = 1'b0;
      bus.goal_right = 1'b0;
      #1;
   endtask

   initial begin
      bus.start_btn  = 1'b1;
      bus.goal_left  = 1'b0;
      bus.goal_right = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("held_btn_idle", 32'(bus.state), 0);
      check("held_btn_no_br", 32'(bus.ball_reset), 0);

      bus.start_btn = 1'b0;
      @(negedge clk);
      bus.start_btn = 1'b1;
      @(negedge clk); #1;
      check("start_state", 32'(bus.state), 1);
      check("start_br", 32'(bus.ball_reset), 1);
      check("start_dir", 32'(bus.serve_dir), 1);
      check("start_scores", 32'({bus.p1_score, bus.p2_score}), 0);
      @(negedge clk); #1;
      check("br_one_clk", 32'(bus.ball_reset), 0);

      pulse(1'b0, 1'b1);
      check("serve_goal_ignored", 32'(bus.p1_score), 0);
      wait_state(2, 40);
      check("rally_enable", 32'(bus.ball_enable), 1);

      pulse(1'b1, 1'b0);
      check("gl_p2", 32'(bus.p2_score), 1);
      check("gl_dir", 32'(bus.serve_dir), 0);
      check("gl_state", 32'(bus.state), 3);
      check("gl_en", 32'(bus.ball_enable), 0);
      wait_state(1, 60);
      check("reserve_br", 32'(bus.ball_reset), 1);

      wait_state(2, 40);
      pulse(1'b1, 1'b1);
      check("both_state", 32'(bus.state), 3);
      check("both_scores", 32'({bus.p1_score, bus.p2_score}), 32'h01);
      check("both_dir", 32'(bus.serve_dir), 0);

      wait_state(2, 60);
      pulse(1'b0, 1'b1);
      check("gr_p1", 32'(bus.p1_score), 1);
      check("gr_dir", 32'(bus.serve_dir), 1);
      wait_state(2, 60);
      pulse(1'b0, 1'b1);
      wait_state(4, 60);
      check("go_winner", 32'(bus.winner), 1);
      check("go_p1", 32'(bus.p1_score), 2);
      bus.start_btn = 1'b0;
      @(negedge clk);
      bus.start_btn = 1'b1;
      @(negedge clk); #1;
      check("restart_state", 32'(bus.state), 1);
      check("restart_scores", 32'({bus.p1_score, bus.p2_score}), 0);
      check("restart_winner", 32'(bus.winner), 0);

      wait_state(2, 40);
      pulse(1'b0, 1'b1);
      wait_state(2, 60);
      check("pre_reset_p1", 32'(bus.p1_score), 1);
      reset = 1'b1;
      @(negedge clk); #1;
      check("rst_state", 32'(bus.state), 0);
      check("rst_p1", 32'(bus.p1_score), 0);
      check("rst_en", 32'(bus.ball_enable), 0);
      check("rst_dir", 32'(bus.serve_dir), 1);
      reset = 1'b0;

      repeat (5000) begin
         @(negedge clk);
         bus.goal_left  = ($urandom_range(0, 11) == 0);
         bus.goal_right = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 24) == 0) bus.start_btn = ~bus.start_btn;
         reset = ($urandom_range(0, 699) == 0);
      end
      @(negedge clk);
      reset = 1'b0;
      bus.goal_left  = 1'b0;
      bus.goal_right = 1'b0;
      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pong_match_controller.md
Name:
pong_match_controller

Overview:
Match-level sequencer for the Pong game. Sits above the ball/paddle engine and sequences each match through idle, serve, rally, point-hold and game-over. It owns both scores, gates ball motion, requests ball re-centring and picks the serve direction. Event inputs come from the ball engine's boundary checks; timing is counted in VGA frames, not raw clocks.

Parameters:
WIN_SCORE, 5, points needed to win; legal range 1..15
SERVE_DELAY_FRAMES, 60, frames the ball sits centred before a rally starts; minimum 1
POINT_HOLD_FRAMES, 90, frames frozen after a point before the next serve or game over; minimum 1
CNT_W, 10, frame-counter width; must hold max(SERVE_DELAY_FRAMES, POINT_HOLD_FRAMES)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-clk pulse per video frame, at vCounter wrap
start_btn  in  1  level; rising edge starts a match
goal_left  in  1  one-clk pulse; ball crossed left boundary, player 2 scores
goal_right  in  1  one-clk pulse; ball crossed right boundary, player 1 scores
ball_enable  out  1  ball engine may move the ball
ball_reset  out  1  one-clk pulse; engine re-centres the ball and loads serve_dir
serve_dir  out  1  1 = serve toward the right, 0 = toward the left
p1_score  out  4  player 1 score
p2_score  out  4  player 2 score
winner  out  2  0 = none, 1 = player 1, 2 = player 2
state  out  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, GAME_OVER=4

Behaviour:
- Reset and clock: clock is clk; reset is synchronous, active-high.
- Reset values:
  - state = IDLE
  - p1_score = 0, p2_score = 0, winner = 0
  - ball_enable = 0, ball_reset = 0, serve_dir = 1
  - frame counter = 0
  - start edge-detect register = 1, so a button held through reset must be released before it can start a match.
- Start edge: start_btn registered once, start_rise = start_btn & ~start_q.
- Output timing: all outputs are registered. ball_enable = 1 exactly while state == RALLY. ball_reset is high for exactly one cycle, the first cycle of every SERVE entry.
- IDLE:
  - ball_enable = 0.
  - On start_rise: scores cleared, winner = 0, serve_dir = 1, counter = 0, go to SERVE (ball_reset asserted).
  - Goals are ignored.
- SERVE:
  - On each frame_tick: if counter == SERVE_DELAY_FRAMES-1, clear the counter and go to RALLY; otherwise increment the counter.
  - Goals and start_rise are ignored.
- RALLY:
  - goal_left only: p2_score += 1, serve_dir = 0 (serve toward the conceding player), go to POINT.
  - goal_right only: p1_score += 1, serve_dir = 1, go to POINT.
  - Both in the same cycle: no score change, serve_dir unchanged, go to POINT (replay).
  - A goal takes priority over a coincident frame_tick.
  - start_rise is ignored.
- POINT:
  - ball_enable = 0.
  - Count frame_ticks to POINT_HOLD_FRAMES-1, then:
    - if p1_score >= WIN_SCORE: winner = 1, go to GAME_OVER;
    - else if p2_score >= WIN_SCORE: winner = 2, go to GAME_OVER;
    - else go to SERVE (ball_reset asserted).
  - Goals are ignored.
- GAME_OVER:
  - Scores and winner are held.
  - start_rise behaves as in IDLE: clears scores and winner and enters SERVE.
- Score width: scores can never exceed WIN_SCORE, because a score reaching WIN_SCORE always leads to GAME_OVER. The adders need no saturation.
- Counter: cleared on every state change. Only frame_tick advances it.
- Reset mid-operation (any state, any counter value): returns to the reset values on the next edge. A ball_reset pulse in flight is dropped.
- frame_tick asserted on the same cycle as a state entry does count toward the new state's delay.

Test Plan:
Use WIN_SCORE=2, SERVE_DELAY_FRAMES=2, POINT_HOLD_FRAMES=3, frame_tick every 8 clks.
- Reset with start_btn held high -> stays IDLE, no ball_reset. Release, then press -> ball_reset pulses for 1 clk, state=1, serve_dir=1, scores 0/0.
- From SERVE, 2 frame_ticks -> state=2 and ball_enable=1 the clk after the 2nd tick. goal_right pulses issued during SERVE have no effect.
- In RALLY, pulse goal_left -> p2_score=1, serve_dir=0, state=3, ball_enable=0. After 3 ticks -> state=1 with a 1-clk ball_reset.
- In RALLY, pulse goal_left and goal_right in the same clk -> scores unchanged, state=3, serve_dir unchanged.
- Two goal_right points -> after the 2nd point's 3-tick hold: state=4, winner=1, p1_score=2. start_rise -> scores 0/0, winner=0, state=1.
- Assert reset mid-RALLY with p1_score=1 -> next clk: state=0, scores 0, ball_enable=0, serve_dir=1.
